// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the AXI4-to-SRAM responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axi_mem_pkg;

   localparam int unsigned AXI_ADDR_W = 64;
   localparam int unsigned AXI_DATA_W = 64;
   localparam int unsigned AXI_ID_W   = 4;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_DATA,
      WR_DATA,
      WR_RESP
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   // Address-channel payloads; cache/prot/atop are carried but ignored.
   typedef struct packed {
      logic [AXI_ID_W-1:0]   id;
      logic [AXI_ADDR_W-1:0] addr;
      logic [7:0]            len;
      logic [2:0]            size;
      logic [1:0]            burst;
      logic [3:0]            cache;
      logic [2:0]            prot;
      logic [5:0]            atop;
   } aw_chan_t;

   typedef struct packed {
      logic [AXI_ID_W-1:0]   id;
      logic [AXI_ADDR_W-1:0] addr;
      logic [7:0]            len;
      logic [2:0]            size;
      logic [1:0]            burst;
      logic [3:0]            cache;
      logic [2:0]            prot;
   } ar_chan_t;

   typedef struct packed {
      logic [AXI_DATA_W-1:0]   data;
      logic [AXI_DATA_W/8-1:0] strb;
      logic                    last;
   } w_chan_t;

   typedef struct packed {
      logic [AXI_ID_W-1:0] id;
      logic [1:0]          resp;
   } b_chan_t;

   typedef struct packed {
      logic [AXI_ID_W-1:0]   id;
      logic [AXI_DATA_W-1:0] data;
      logic [1:0]            resp;
      logic                  last;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } axi_rsp_t;

endpackage

// File: rtl/axi_mem_addr_gen.sv
// Beat address, SRAM word address and error decode for one burst beat.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle from the latched burst state.
module axi_mem_addr_gen
   import axi_mem_pkg::*;
#(
   parameter int unsigned AxiAddrWidth = 64,
   parameter int unsigned AxiDataWidth = 64,
   parameter int unsigned MemWords     = 65536
) (
   input  logic [AxiAddrWidth-1:0]     start_addr,
   input  logic [2:0]                  size,
   input  logic [1:0]                  burst,
   input  logic [7:0]                  beat,
   output logic [AxiAddrWidth-1:0]     beat_addr,
   output logic [$clog2(MemWords)-1:0] word_addr,
   output logic                        err
);

   localparam int unsigned OffW  = $clog2(AxiDataWidth/8);
   localparam int unsigned WordW = $clog2(MemWords);
   localparam logic [2:0]  MaxSize = 3'(OffW);
   localparam logic [AxiAddrWidth-1:0] Range = AxiAddrWidth'(MemWords * (AxiDataWidth/8));

   // FIXED holds the start address, INCR steps by the beat size; WRAP and the
   // reserved encoding are not supported and are flagged as slave errors.
   always_comb begin
      beat_addr = start_addr;
      if (burst == BURST_INCR) begin
         beat_addr = start_addr + (AxiAddrWidth'(beat) << size);
      end
      word_addr = beat_addr[OffW +: WordW];
      err = ((burst != BURST_FIXED) && (burst != BURST_INCR))
         || (size > MaxSize)
         || (beat_addr >= Range);
   end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave terminating a master onto a single-port synchronous SRAM, one transaction at a time.
// Latency: R beat valid 2 cycles after AR handshake, 1 read beat per 2 cycles; W accepted every cycle.
// Backpressure: R/B held stable until ready; AW/AR/W ready only in the state that consumes them.
module axi_mem_responder
   import axi_mem_pkg::*;
#(
   parameter int unsigned AxiAddrWidth = AXI_ADDR_W,
   parameter int unsigned AxiDataWidth = AXI_DATA_W,
   parameter int unsigned AxiIdWidth   = AXI_ID_W,
   parameter int unsigned MemWords     = 65536,
   parameter type axi_req_t = axi_mem_pkg::axi_req_t,
   parameter type axi_rsp_t = axi_mem_pkg::axi_rsp_t
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  axi_req_t                    axi_req_i,
   output axi_rsp_t                    axi_resp_o,
   output logic                        mem_req_o,
   output logic                        mem_we_o,
   output logic [$clog2(MemWords)-1:0] mem_addr_o,
   output logic [AxiDataWidth-1:0]     mem_wdata_o,
   output logic [AxiDataWidth/8-1:0]   mem_be_o,
   input  logic [AxiDataWidth-1:0]     mem_rdata_i
);

   state_t state_q, state_d;

   logic                    favour_wr_q;
   logic [AxiIdWidth-1:0]   id_q;
   logic [AxiAddrWidth-1:0] addr_q;
   logic [7:0]              len_q;
   logic [2:0]              size_q;
   logic [1:0]              burst_q;
   logic [7:0]              beat_q;
   logic [AxiDataWidth-1:0] r_data_q;
   logic [1:0]              r_resp_q;
   logic                    r_last_q;
   logic                    rd_first_q;
   logic                    wr_err_q;

   logic                    aw_rdy, ar_rdy, w_rdy, b_vld, r_vld;
   logic                    grant_rd, grant_wr;
   logic [AxiDataWidth-1:0] r_data_w;
   logic [AxiAddrWidth-1:0] beat_addr;
   logic                    beat_err;

   axi_mem_addr_gen #(
      .AxiAddrWidth (AxiAddrWidth),
      .AxiDataWidth (AxiDataWidth),
      .MemWords     (MemWords)
   ) u_addr_gen (
      .start_addr (addr_q),
      .size       (size_q),
      .burst      (burst_q),
      .beat       (beat_q),
      .beat_addr  (beat_addr),
      .word_addr  (mem_addr_o),
      .err        (beat_err)
   );

   // When both address channels request together, serve the type not served last.
   assign grant_rd = axi_req_i.ar_valid && (!axi_req_i.aw_valid || !favour_wr_q);
   assign grant_wr = axi_req_i.aw_valid && (!axi_req_i.ar_valid ||  favour_wr_q);

   // The first RD_DATA cycle forwards SRAM data directly; later stall cycles replay the capture.
   assign r_data_w = rd_first_q ? ((r_resp_q == RESP_SLVERR) ? '0 : mem_rdata_i) : r_data_q;

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state, handshakes and SRAM strobes.
   always_comb begin
      state_d     = state_q;
      aw_rdy      = 1'b0;
      ar_rdy      = 1'b0;
      w_rdy       = 1'b0;
      b_vld       = 1'b0;
      r_vld       = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      case (state_q)
         IDLE: begin
            if (grant_rd) begin
               ar_rdy  = 1'b1;
               state_d = RD_REQ;
            end else if (grant_wr) begin
               aw_rdy  = 1'b1;
               state_d = WR_DATA;
            end
         end
         RD_REQ: begin
            mem_req_o = !beat_err;
            state_d   = RD_DATA;
         end
         RD_DATA: begin
            r_vld = 1'b1;
            if (axi_req_i.r_ready) state_d = r_last_q ? IDLE : RD_REQ;
         end
         WR_DATA: begin
            w_rdy = 1'b1;
            if (axi_req_i.w_valid) begin
               mem_req_o   = !beat_err;
               mem_we_o    = !beat_err;
               mem_wdata_o = axi_req_i.w.data;
               mem_be_o    = axi_req_i.w.strb;
               if (beat_q == len_q) state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            b_vld = 1'b1;
            if (axi_req_i.b_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Burst context, beat counter, read-data capture and sticky write error.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         favour_wr_q <= 1'b0;
         id_q        <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         beat_q      <= '0;
         r_data_q    <= '0;
         r_resp_q    <= RESP_OKAY;
         r_last_q    <= 1'b0;
         rd_first_q  <= 1'b0;
         wr_err_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (ar_rdy) begin
                  favour_wr_q <= 1'b1;
                  id_q        <= axi_req_i.ar.id;
                  addr_q      <= axi_req_i.ar.addr;
                  len_q       <= axi_req_i.ar.len;
                  size_q      <= axi_req_i.ar.size;
                  burst_q     <= axi_req_i.ar.burst;
                  beat_q      <= '0;
               end else if (aw_rdy) begin
                  favour_wr_q <= 1'b0;
                  id_q        <= axi_req_i.aw.id;
                  addr_q      <= axi_req_i.aw.addr;
                  len_q       <= axi_req_i.aw.len;
                  size_q      <= axi_req_i.aw.size;
                  burst_q     <= axi_req_i.aw.burst;
                  beat_q      <= '0;
                  wr_err_q    <= 1'b0;
               end
            end
            RD_REQ: begin
               r_resp_q   <= beat_err ? RESP_SLVERR : RESP_OKAY;
               r_last_q   <= (beat_q == len_q);
               rd_first_q <= 1'b1;
            end
            RD_DATA: begin
               rd_first_q <= 1'b0;
               if (rd_first_q) r_data_q <= r_data_w;
               if (axi_req_i.r_ready && !r_last_q) beat_q <= beat_q + 8'd1;
            end
            WR_DATA: begin
               if (axi_req_i.w_valid) begin
                  if (beat_err) wr_err_q <= 1'b1;
                  if (beat_q != len_q) beat_q <= beat_q + 8'd1;
               end
            end
            WR_RESP: begin
               if (axi_req_i.b_ready) wr_err_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Drive the response struct from the FSM outputs and burst registers.
   always_comb begin
      axi_resp_o          = '0;
      axi_resp_o.aw_ready = aw_rdy;
      axi_resp_o.ar_ready = ar_rdy;
      axi_resp_o.w_ready  = w_rdy;
      axi_resp_o.b_valid  = b_vld;
      axi_resp_o.b.id     = id_q;
      axi_resp_o.b.resp   = wr_err_q ? RESP_SLVERR : RESP_OKAY;
      axi_resp_o.r_valid  = r_vld;
      axi_resp_o.r.id     = id_q;
      axi_resp_o.r.data   = r_data_w;
      axi_resp_o.r.resp   = r_resp_q;
      axi_resp_o.r.last   = r_last_q;
   end

   // Sideband fields and w_last carry no meaning for this memory.
   logic unused_ok;
   assign unused_ok = ^{beat_addr, axi_req_i.aw.cache, axi_req_i.aw.prot, axi_req_i.aw.atop,
                        axi_req_i.ar.cache, axi_req_i.ar.prot, axi_req_i.w.last};

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder with a behavioural SRAM.
// Latency: checks R valid two cycles after the AR handshake.
// Backpressure: holds r_ready low mid-burst and checks R stability.
module tb_axi_mem_responder;

   logic                 clk_i = 1'b0;
   logic                 rst_i = 1'b1;
   axi_mem_pkg::axi_req_t req;
   axi_mem_pkg::axi_rsp_t rsp;
   logic                 mem_req_o, mem_we_o;
   logic [15:0]          mem_addr_o;
   logic [63:0]          mem_wdata_o;
   logic [7:0]           mem_be_o;
   logic [63:0]          mem_rdata_i = '0;

   logic [63:0] sram [0:65535];
   logic        pl_en = 1'b0;
   logic [15:0] pl_addr = '0;
   logic [63:0] pl_data = '0;
   int          rd_cnt = 0;
   int          errors = 0;
   int          checks = 0;

   always #5 clk_i = ~clk_i;

   axi_mem_responder dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .axi_req_i   (req),
      .axi_resp_o  (rsp),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_be_o    (mem_be_o),
      .mem_rdata_i (mem_rdata_i)
   );

   // Behavioural SRAM: byte-enabled writes, 1-cycle read data, junk when idle.
   always @(posedge clk_i) begin
      if (pl_en) sram[pl_addr] <= pl_data;
      if (mem_req_o && mem_we_o) begin
         for (int b = 0; b < 8; b++)
            if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end
      if (mem_req_o && !mem_we_o) begin
         mem_rdata_i <= sram[mem_addr_o];
         rd_cnt      <= rd_cnt + 1;
      end else begin
         mem_rdata_i <= 64'hBAD0_BAD0_BAD0_BAD0;
      end
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic preload(input logic [15:0] a, input logic [63:0] d);
      pl_addr = a;
      pl_data = d;
      pl_en   = 1'b1;
      cyc();
      pl_en   = 1'b0;
   endtask

   task automatic ar_send(input logic [63:0] a, input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] id);
      int n = 0;
      req.ar.addr = a; req.ar.len = len; req.ar.size = 3'd3; req.ar.burst = burst; req.ar.id = id;
      req.ar_valid = 1'b1;
      #1;
      while (!rsp.ar_ready && n < 50) begin cyc(); n++; end
      check("ar_handshake", rsp.ar_ready, 1'b1);
      cyc();
      req.ar_valid = 1'b0;
   endtask

   task automatic aw_send(input logic [63:0] a, input logic [7:0] len, input logic [3:0] id);
      int n = 0;
      req.aw.addr = a; req.aw.len = len; req.aw.size = 3'd3;
      req.aw.burst = axi_mem_pkg::BURST_INCR; req.aw.id = id;
      req.aw_valid = 1'b1;
      #1;
      while (!rsp.aw_ready && n < 50) begin cyc(); n++; end
      check("aw_handshake", rsp.aw_ready, 1'b1);
      cyc();
      req.aw_valid = 1'b0;
   endtask

   task automatic w_send(input logic [63:0] d, input logic [7:0] strb);
      int n = 0;
      req.w.data = d; req.w.strb = strb; req.w.last = 1'b0;
      req.w_valid = 1'b1;
      #1;
      while (!rsp.w_ready && n < 50) begin cyc(); n++; end
      check("w_handshake", rsp.w_ready, 1'b1);
      cyc();
      req.w_valid = 1'b0;
   endtask

   task automatic b_get(output logic [3:0] id, output logic [1:0] resp);
      int n = 0;
      req.b_ready = 1'b1;
      #1;
      while (!rsp.b_valid && n < 50) begin cyc(); n++; end
      check("b_wait", rsp.b_valid, 1'b1);
      id = rsp.b.id; resp = rsp.b.resp;
      cyc();
      req.b_ready = 1'b0;
   endtask

   task automatic rd_beat(output logic [63:0] d, output logic [1:0] resp, output logic last,
                          output logic [3:0] id);
      int n = 0;
      req.r_ready = 1'b1;
      #1;
      while (!rsp.r_valid && n < 50) begin cyc(); n++; end
      check("r_wait", rsp.r_valid, 1'b1);
      d = rsp.r.data; resp = rsp.r.resp; last = rsp.r.last; id = rsp.r.id;
      cyc();
      req.r_ready = 1'b0;
   endtask

   initial begin
      logic [63:0] d, d0;
      logic [1:0]  rs;
      logic        l, l0;
      logic [3:0]  id;
      int          bad, snap, n;

      req = '0;
      // Preloads happen while reset is held.
      preload(16'd4, 64'hDEADBEEF_CAFEF00D);
      preload(16'd5, 64'h0000_0000_0000_0055);
      preload(16'd0, 64'h0000_0000_0000_1111);
      for (int i = 0; i < 4; i++) preload(16'(64 + i), 64'h1000_0000_0000_00A0 + 64'(i));

      check("rst_r_valid", rsp.r_valid, 1'b0);
      check("rst_b_valid", rsp.b_valid, 1'b0);
      check("rst_mem_req", mem_req_o, 1'b0);
      check("rst_mem_we", mem_we_o, 1'b0);
      check("rst_r_data", rsp.r.data, 64'h0);
      check("rst_r_last", rsp.r.last, 1'b0);
      check("rst_b_resp", rsp.b.resp, 2'b00);
      rst_i = 1'b0;
      cyc();

      // Simultaneous AR/AW after reset: read goes first. Read is the single-beat test.
      req.ar.addr = 64'h20; req.ar.len = 8'd0; req.ar.size = 3'd3;
      req.ar.burst = axi_mem_pkg::BURST_INCR; req.ar.id = 4'd5;
      req.aw.addr = 64'h100; req.aw.len = 8'd3; req.aw.size = 3'd3;
      req.aw.burst = axi_mem_pkg::BURST_INCR; req.aw.id = 4'd9;
      req.ar_valid = 1'b1; req.aw_valid = 1'b1;
      #1;
      check("arb1_ar_ready", rsp.ar_ready, 1'b1);
      check("arb1_aw_ready", rsp.aw_ready, 1'b0);
      cyc();
      req.ar_valid = 1'b0;
      #1;
      check("rd1_mem_req", mem_req_o, 1'b1);
      check("rd1_mem_addr", mem_addr_o, 16'd4);
      check("rd1_r_valid_early", rsp.r_valid, 1'b0);
      check("busy_aw_ready", rsp.aw_ready, 1'b0);
      cyc();
      check("rd1_r_valid", rsp.r_valid, 1'b1);
      check("rd1_data", rsp.r.data, 64'hDEADBEEF_CAFEF00D);
      check("rd1_id", rsp.r.id, 4'd5);
      check("rd1_resp", rsp.r.resp, 2'b00);
      check("rd1_last", rsp.r.last, 1'b1);
      // Accept the beat and present a second read alongside the still-pending write.
      req.r_ready = 1'b1;
      req.ar.addr = 64'h28; req.ar.id = 4'd3;
      req.ar_valid = 1'b1;
      cyc();
      req.r_ready = 1'b0;
      #1;
      check("arb2_aw_ready", rsp.aw_ready, 1'b1);
      check("arb2_ar_ready", rsp.ar_ready, 1'b0);
      cyc();
      req.aw_valid = 1'b0;

      // INCR write burst, 4 beats to words 32..35.
      for (int i = 1; i <= 4; i++) w_send(64'(i), 8'hFF);
      b_get(id, rs);
      check("wr_b_id", id, 4'd9);
      check("wr_b_resp", rs, 2'b00);
      for (int i = 0; i < 4; i++) check("wr_mem", sram[32 + i], 64'(i + 1));

      // The pending read from word 5.
      ar_send(64'h28, 8'd0, axi_mem_pkg::BURST_INCR, 4'd3);
      rd_beat(d, rs, l, id);
      check("rd2_data", d, 64'h55);
      check("rd2_id", id, 4'd3);

      // Backpressure on beat 2 of a 4-beat read.
      ar_send(64'h200, 8'd3, axi_mem_pkg::BURST_INCR, 4'd2);
      for (int i = 0; i < 2; i++) begin
         rd_beat(d, rs, l, id);
         check("bp_data", d, 64'h1000_0000_0000_00A0 + 64'(i));
         check("bp_last", l, 1'b0);
      end
      n = 0;
      while (!rsp.r_valid && n < 50) begin cyc(); n++; end
      check("bp_stall_valid", rsp.r_valid, 1'b1);
      d0 = rsp.r.data; l0 = rsp.r.last; bad = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (rsp.r.data !== d0 || rsp.r.last !== l0 || rsp.r_valid !== 1'b1) bad++;
      end
      check("bp_stable", bad, 0);
      check("bp_stall_data", d0, 64'h1000_0000_0000_00A2);
      rd_beat(d, rs, l, id);
      check("bp_b2_data", d, 64'h1000_0000_0000_00A2);
      check("bp_b2_last", l, 1'b0);
      rd_beat(d, rs, l, id);
      check("bp_b3_data", d, 64'h1000_0000_0000_00A3);
      check("bp_b3_last", l, 1'b1);
      bad = 0;
      for (int i = 0; i < 3; i++) begin cyc(); if (rsp.r_valid) bad++; end
      check("bp_no_extra", bad, 0);

      // Write straddling the end of memory: second beat must not touch word 0.
      aw_send(64'h7FFF8, 8'd1, 4'd6);
      w_send(64'h5555_AAAA_5555_AAAA, 8'hFF);
      w_send(64'h6666_6666_6666_6666, 8'hFF);
      b_get(id, rs);
      check("err_b_resp", rs, 2'b10);
      check("err_b_id", id, 4'd6);
      check("err_beat0", sram[16'hFFFF], 64'h5555_AAAA_5555_AAAA);
      check("err_word0", sram[0], 64'h1111);

      // WRAP read: every beat SLVERR with zero data, no SRAM strobes.
      snap = rd_cnt;
      ar_send(64'h40, 8'd3, axi_mem_pkg::BURST_WRAP, 4'd7);
      for (int i = 0; i < 4; i++) begin
         rd_beat(d, rs, l, id);
         check("wrap_resp", rs, 2'b10);
         check("wrap_data", d, 64'h0);
         check("wrap_last", l, (i == 3));
      end
      check("wrap_strobes", rd_cnt - snap, 0);

      // Reset during beat 2 of an 8-beat write.
      aw_send(64'h300, 8'd7, 4'd4);
      w_send(64'hA, 8'hFF);
      w_send(64'hB, 8'hFF);
      req.w.data = 64'hC; req.w_valid = 1'b1;
      #1;
      check("mr_w_ready", rsp.w_ready, 1'b1);
      check("mr_mem_req", mem_req_o, 1'b1);
      rst_i = 1'b1;
      #1;
      check("mr_rst_mem_req", mem_req_o, 1'b0);
      check("mr_rst_mem_we", mem_we_o, 1'b0);
      check("mr_rst_w_ready", rsp.w_ready, 1'b0);
      check("mr_rst_b_valid", rsp.b_valid, 1'b0);
      cyc();
      rst_i = 1'b0;
      req.w_valid = 1'b0;
      req.b_ready = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin cyc(); if (rsp.b_valid) bad++; end
      req.b_ready = 1'b0;
      check("mr_no_b", bad, 0);
      ar_send(64'h100, 8'd0, axi_mem_pkg::BURST_INCR, 4'd1);
      rd_beat(d, rs, l, id);
      check("mr_rd_data", d, 64'h1);
      check("mr_rd_id", id, 4'd1);
      check("mr_rd_last", l, 1'b1);
      check("mr_rd_resp", rs, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1);
   end

endmodule
